// File: rtl/cordic_vect_post.sv
// Output stage of the vectoring CORDIC: tracks sample tags alongside the core,
// fixes up the angle for half-plane pre-rotation, removes CORDIC gain, and buffers results.
module cordic_vect_post #(
    parameter int N      = 16,
    parameter int LAT    = 16,
    parameter int DEPTH  = 32,
    parameter int K_GAIN = 19899
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_flip,
    input  logic signed [N-1:0] c_x,
    input  logic signed [N-1:0] c_ang,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [N-1:0]        m_mag,
    output logic signed [N-1:0] m_ang,
    output logic                err_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int UW = $clog2(DEPTH + 1);
    localparam logic [UW-1:0]         USED_MAX  = UW'(DEPTH);
    localparam logic signed [2*N-1:0] K_EXT     = (2*N)'(K_GAIN);
    localparam logic signed [2*N-1:0] MAG_MAX   = (2*N)'((2**(N-1)) - 1);
    localparam logic signed [N-1:0]   HALF_TURN = N'(18000);
    localparam logic [PW:0]           OCC_FULL  = {1'b1, {PW{1'b0}}};

    logic                accept;
    logic                pop;
    logic                full;
    logic                do_write;
    logic [LAT-1:0]      tag_valid;
    logic [LAT-1:0]      tag_flip;
    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] prod_sh;
    logic [N-1:0]        mag_next;
    logic signed [N-1:0] ang_next;
    logic                p_valid;
    logic [N-1:0]        p_mag;
    logic [N-1:0]        p_ang;
    logic [2*N-1:0]      mem [DEPTH];
    logic [PW:0]         wr_ptr;
    logic [PW:0]         rd_ptr;
    logic [PW:0]         occupancy;
    logic [UW-1:0]       used;

    assign accept  = s_valid & s_ready;
    assign s_ready = rst & (used < USED_MAX);

    // Tags ride a free-running shift register that mirrors the non-stallable core.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_valid <= '0;
            tag_flip  <= '0;
        end else begin
            tag_valid <= {tag_valid[LAT-2:0], accept};
            tag_flip  <= {tag_flip[LAT-2:0], s_flip};
        end
    end

    always_comb begin
        prod     = $signed({{N{c_x[N-1]}}, c_x}) * K_EXT;
        prod_sh  = prod >>> 15;
        mag_next = '0;
        if (c_x[N-1])
            mag_next = '0;
        else if (prod_sh > MAG_MAX)
            mag_next = MAG_MAX[N-1:0];
        else
            mag_next = prod_sh[N-1:0];
    end

    // N-bit modular add equals the N+1-bit sum truncated to N bits.
    always_comb begin
        ang_next = c_ang;
        if (tag_flip[LAT-1]) begin
            if (c_ang <= 0)
                ang_next = c_ang + HALF_TURN;
            else
                ang_next = c_ang - HALF_TURN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_valid <= 1'b0;
            p_mag   <= '0;
            p_ang   <= '0;
        end else begin
            p_valid <= tag_valid[LAT-1];
            if (tag_valid[LAT-1]) begin
                p_mag <= mag_next;
                p_ang <= ang_next;
            end
        end
    end

    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == OCC_FULL);
    assign m_valid   = (occupancy != '0);
    assign pop       = m_valid & m_ready;
    assign do_write  = p_valid & (~full | pop);
    assign m_mag     = m_valid ? mem[rd_ptr[PW-1:0]][2*N-1:N] : '0;
    assign m_ang     = m_valid ? $signed(mem[rd_ptr[PW-1:0]][N-1:0]) : '0;

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr[PW-1:0]] <= {p_mag, p_ang};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            err_ovf <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PW+1)'(1);
            if (p_valid & full & ~pop)
                err_ovf <= 1'b1;
        end
    end

    // Credits cover both in-flight core samples and stored results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            used <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   used <= used + UW'(1);
                2'b01:   used <= used - UW'(1);
                default: used <= used;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vect_post.sv
// Directed bench for cordic_vect_post with a behavioural LAT-deep core model
// and an in-order result scoreboard.
module tb_cordic_vect_post;

    localparam int N     = 16;
    localparam int LAT   = 16;
    localparam int DEPTH = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                s_valid;
    logic                s_ready;
    logic                s_flip;
    logic signed [N-1:0] c_x;
    logic signed [N-1:0] c_ang;
    logic                m_valid;
    logic                m_ready;
    logic [N-1:0]        m_mag;
    logic signed [N-1:0] m_ang;
    logic                err_ovf;

    always #5 clk = ~clk;

    cordic_vect_post #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .K_GAIN(19899)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_flip(s_flip),
        .c_x(c_x), .c_ang(c_ang),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_mag(m_mag), .m_ang(m_ang), .err_ovf(err_ovf)
    );

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] ang;
        logic               flip;
        logic [15:0]        e_mag;
        logic signed [15:0] e_ang;
    } vec_t;

    typedef struct {
        logic [15:0]        mag;
        logic signed [15:0] ang;
    } res_t;

    res_t exp_q[$];
    int   pop_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   accepts  = 0;
    int   cycle    = 0;

    logic signed [15:0] cur_x, cur_ang, cur_eang;
    logic [15:0]        cur_emag;
    logic signed [15:0] cap_x, cap_ang;
    logic               cap_acc;
    logic signed [15:0] pipe_x [LAT];
    logic signed [15:0] pipe_a [LAT];

    function automatic logic [15:0] model_mag(input logic signed [15:0] x);
        longint p;
        if (x < 0) return 16'd0;
        p = (longint'(x) * 19899) / 32768;
        if (p > 32767) p = 32767;
        return 16'(p);
    endfunction

    function automatic logic signed [15:0] model_ang(input logic signed [15:0] a, input logic f);
        int r;
        r = int'(a);
        if (f) r = (r <= 0) ? r + 18000 : r - 18000;
        return 16'(r);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Core model: whatever is accepted reappears on c_x/c_ang LAT clocks later.
    always begin
        @(posedge clk);
        cycle++;
        cap_acc = s_valid && s_ready;
        cap_x   = cur_x;
        cap_ang = cur_ang;
        if (!rst) begin
            exp_q.delete();
        end else if (cap_acc) begin
            exp_q.push_back('{cur_emag, cur_eang});
            accepts++;
        end
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_x[i] = pipe_x[i-1];
            pipe_a[i] = pipe_a[i-1];
        end
        pipe_x[0] = cap_acc ? cap_x : 16'($urandom);
        pipe_a[0] = cap_acc ? cap_ang : 16'($urandom);
        c_x   = pipe_x[LAT-1];
        c_ang = pipe_a[LAT-1];
    end

    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious m_valid", int'(m_valid), 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                checkOutput("m_mag", int'(m_mag), int'(e.mag));
                checkOutput("m_ang", int'(m_ang), int'(e.ang));
            end
            pop_cyc.push_back(cycle);
        end
    end

    task automatic setSample(input logic signed [15:0] x, input logic signed [15:0] a, input logic f);
        cur_x    = x;
        cur_ang  = a;
        s_flip   = f;
        cur_emag = model_mag(x);
        cur_eang = model_ang(a, f);
    endtask

    task automatic applyStimulus(input vec_t v);
        int k;
        cur_x    = v.x;
        cur_ang  = v.ang;
        s_flip   = v.flip;
        cur_emag = v.e_mag;
        cur_eang = v.e_ang;
        s_valid  = 1'b1;
        k = 0;
        while (!s_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) checkOutput("accept timeout s_ready", int'(s_ready), 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl[11];
        int   cnt, acc0, pops0, drops, mv_seen;

        tbl[0]  = '{16'sd1646,   16'sd0,      1'b0, 16'd999,   16'sd0};
        tbl[1]  = '{16'sd1646,   16'sd4500,   1'b1, 16'd999,  -16'sd13500};
        tbl[2]  = '{16'sd1646,  -16'sd4500,   1'b1, 16'd999,   16'sd13500};
        tbl[3]  = '{16'sd1646,   16'sd0,      1'b1, 16'd999,   16'sd18000};
        tbl[4]  = '{-16'sd5,     16'sd100,    1'b0, 16'd0,     16'sd100};
        tbl[5]  = '{16'sd32767, -16'sd17999,  1'b0, 16'd19898,-16'sd17999};
        tbl[6]  = '{16'sd1000,   16'sd18000,  1'b1, 16'd607,   16'sd0};
        tbl[7]  = '{16'sd100,   -16'sd18000,  1'b1, 16'd60,    16'sd0};
        tbl[8]  = '{16'sd0,      16'sd0,      1'b0, 16'd0,     16'sd0};
        tbl[9]  = '{-16'sd32768,-16'sd100,    1'b1, 16'd0,     16'sd17900};
        tbl[10] = '{16'sd16384,  16'sd9000,   1'b0, 16'd9949,  16'sd9000};

        rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        setSample(16'sd0, 16'sd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("s_ready in reset", int'(s_ready), 0);
        rst = 1'b1;
        #1;
        checkOutput("s_ready after reset", int'(s_ready), 1);
        checkOutput("m_valid after reset", int'(m_valid), 0);
        checkOutput("m_mag after reset", int'(m_mag), 0);
        checkOutput("m_ang after reset", int'(m_ang), 0);
        checkOutput("err_ovf after reset", int'(err_ovf), 0);
        @(posedge clk); #1;

        // Directed table: first vector alone to measure latency, rest back to back.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i]);
            if (i == 0) begin
                cnt = 1;
                while (!m_valid && cnt < 40) begin
                    @(posedge clk); #1;
                    cnt++;
                end
                checkOutput("latency accept->m_valid", cnt, 18);
                wait_drain("single sample drained");
            end
        end
        wait_drain("table drained");

        $display("[TB] backpressure");
        m_ready = 1'b0;
        acc0 = accepts;
        s_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            setSample(16'(i * 100 + 50), 16'(i * 10), 1'b0);
            @(posedge clk); #1;
        end
        checkOutput("accepts under backpressure", accepts - acc0, DEPTH);
        checkOutput("s_ready when credits exhausted", int'(s_ready), 0);
        checkOutput("m_valid held", int'(m_valid), 1);
        checkOutput("err_ovf under backpressure", int'(err_ovf), 0);
        pops0 = pop_cyc.size();
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("s_ready after first pop", int'(s_ready), 1);
        wait_drain("backpressure drained");
        checkOutput("backpressure results", pop_cyc.size() - pops0, DEPTH);

        $display("[TB] throughput");
        acc0 = accepts;
        pops0 = pop_cyc.size();
        drops = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            setSample(16'(i * 200 - 3000), 16'(i * 300 - 15000), i[0]);
            if (!s_ready) drops++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        checkOutput("s_ready drops", drops, 0);
        checkOutput("throughput accepts", accepts - acc0, 100);
        wait_drain("throughput drained");
        checkOutput("throughput results", pop_cyc.size() - pops0, 100);
        if (pop_cyc.size() - pops0 == 100)
            checkOutput("result spacing", pop_cyc[pops0 + 99] - pop_cyc[pops0], 99);

        $display("[TB] reset mid-operation");
        acc0 = accepts;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            setSample(16'(i * 500 + 7), 16'(i * 1000), 1'b1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        checkOutput("accepts before reset", accepts - acc0, 10);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        checkOutput("s_ready during mid reset", int'(s_ready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("s_ready after mid reset", int'(s_ready), 1);
        checkOutput("m_valid after mid reset", int'(m_valid), 0);
        checkOutput("used after mid reset", int'(dut.used), 0);
        mv_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (m_valid) mv_seen++;
        end
        checkOutput("stale results after reset", mv_seen, 0);
        checkOutput("err_ovf at end", int'(err_ovf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
